// File: rtl/timeout_scheduler.sv
// timeout_scheduler: round-robin sharing of one wrapping timeout counter among N requesters
module timeout_scheduler #(
  parameter int N       = 4,
  parameter int IDX_W   = 2,
  parameter int W       = 3,
  parameter int TIMEOUT = 6,
  parameter int ZERO    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             tick,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] owner,
  output logic             busy,
  output logic [W-1:0]     time_val,
  output logic [N-1:0]     timeout
);
  typedef enum logic [1:0] {IDLE, COUNT, RELEASE} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] last, last_n, owner_n, sel, cand;
  logic [N-1:0] gnt_n, timeout_n;
  logic [W-1:0] time_n;
  logic found;
  assign busy = state == COUNT;
  // first requester after the last served one, wrapping modulo N
  always_comb begin
    sel = '0;
    found = 1'b0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last) + k) % N);
      if (!found && req[cand]) begin
        sel = cand;
        found = 1'b1;
      end
    end
  end
  // next state: grant in IDLE, abort before expiry in COUNT, single-cycle RELEASE
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    owner_n = owner;
    time_n = time_val;
    timeout_n = '0;
    last_n = last;
    case (state)
      IDLE: if (found) begin
        gnt_n = N'(1) << sel;
        owner_n = sel;
        time_n = W'(ZERO);
        state_n = COUNT;
      end
      COUNT: if (!req[owner]) begin
        gnt_n = '0;
        time_n = W'(ZERO);
        last_n = owner;
        state_n = IDLE;
      end else if (tick && time_val != W'(TIMEOUT)) begin
        time_n = time_val + 1'b1;
      end else if (tick) begin
        time_n = W'(ZERO);
        timeout_n = N'(1) << owner;
        gnt_n = '0;
        last_n = owner;
        state_n = RELEASE;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and output registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      owner <= '0;
      time_val <= W'(ZERO);
      timeout <= '0;
      last <= IDX_W'(N - 1);
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      owner <= owner_n;
      time_val <= time_n;
      timeout <= timeout_n;
      last <= last_n;
    end
  end
endmodule

// File: tb/tb_timeout_scheduler.sv
// tb_timeout_scheduler: randomized and directed checks against a behavioural scheduler model
module tb_timeout_scheduler;
  localparam int TMO = 6;
  logic clk = 0, rst = 0, tick = 0;
  logic [3:0] req = 0;
  logic [3:0] gnt, timeout;
  logic [1:0] owner;
  logic busy;
  logic [2:0] time_val;
  int n_chk = 0, n_fail = 0;
  int mo, mcnt, mlast, mpulse, mrel;

  timeout_scheduler dut (.clk(clk), .rst(rst), .req(req), .tick(tick), .gnt(gnt), .owner(owner),
                         .busy(busy), .time_val(time_val), .timeout(timeout));

  always #5 clk = ~clk;

  function automatic void mreset();
    mo = -1; mcnt = 0; mlast = 3; mpulse = -1; mrel = 0;
  endfunction

  // model: owner -1 means nobody holds the counter; mrel marks the release cycle
  function automatic void model();
    if (rst) begin mreset(); return; end
    mpulse = -1;
    if (mrel) mrel = 0;
    else if (mo >= 0) begin
      if (!req[mo]) begin mlast = mo; mo = -1; mcnt = 0; end
      else if (tick) begin
        if (mcnt == TMO) begin mpulse = mo; mlast = mo; mo = -1; mcnt = 0; mrel = 1; end
        else mcnt++;
      end
    end else begin
      for (int k = 1; k <= 4; k++)
        if (mo < 0 && req[(mlast + k) % 4]) begin mo = (mlast + k) % 4; mcnt = 0; end
    end
  endfunction

  function automatic logic [13:0] expv();
    logic [3:0] g, t;
    g = mo >= 0 ? 4'(1 << mo) : 4'd0;
    t = mpulse >= 0 ? 4'(1 << mpulse) : 4'd0;
    return {g, mo >= 0, mo >= 0 ? 2'(mo) : 2'd0, 3'(mcnt), t};
  endfunction

  function automatic logic [13:0] obs();
    return {gnt, busy, busy ? owner : 2'd0, time_val, timeout};
  endfunction

  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  task automatic test_reset();
    #1 rst = 1;
    #1 n_chk++;
    if (obs() !== 14'd0) begin n_fail++; $display("FAIL reset_async obs=%h exp=0", obs()); end
    mreset();
    step(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      step(); n_chk++;
      if (obs() !== expv()) begin n_fail++; $display("FAIL reset_idle obs=%h exp=%h", obs(), expv()); end
    end
  endtask

  task automatic test_single();
    int edges = 0;
    req = 4'b0001; tick = 1;
    while (timeout == 0 && edges < 20) begin
      step(); edges++; n_chk++;
      if (obs() !== expv()) begin n_fail++; $display("FAIL single obs=%h exp=%h", obs(), expv()); end
    end
    n_chk++;
    if (edges != 8 || timeout !== 4'b0001 || time_val !== 0 || busy !== 0) begin
      n_fail++; $display("FAIL single_expiry edges=%0d to=%b tv=%0d busy=%b exp edges=8 to=0001", edges, timeout, time_val, busy);
    end
    step(); n_chk++;
    if (timeout !== 4'b0000) begin n_fail++; $display("FAIL single_pulse_width to=%b exp=0000", timeout); end
    req = 0; step();
  endtask

  task automatic test_fairness();
    int order[$];
    int want[5] = '{0, 1, 2, 3, 0};
    logic pb;
    do_reset();
    req = 4'b1111; tick = 1; pb = 0;
    for (int i = 0; i < 60 && order.size() < 5; i++) begin
      step(); n_chk++;
      if (obs() !== expv()) begin n_fail++; $display("FAIL fairness obs=%h exp=%h", obs(), expv()); end
      if (busy && !pb) order.push_back(int'(owner));
      pb = busy;
    end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (i >= order.size() || order[i] != want[i]) begin
        n_fail++; $display("FAIL fairness_order idx=%0d got=%0d exp=%0d", i, i < order.size() ? order[i] : -1, want[i]);
      end
    end
    req = 0; step(); step();
  endtask

  task automatic test_tick_gating();
    int ticks = 0;
    logic seen = 0;
    req = 4'b0100;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick = (i % 3) == 2;
      if (busy && tick) ticks++;
      step(); n_chk++;
      if (obs() !== expv()) begin n_fail++; $display("FAIL tick_gating obs=%h exp=%h", obs(), expv()); end
      seen = timeout != 0;
    end
    n_chk++;
    if (!seen || ticks != 7 || timeout !== 4'b0100) begin
      n_fail++; $display("FAIL tick_gating_expiry seen=%b ticks=%0d to=%b exp ticks=7 to=0100", seen, ticks, timeout);
    end
    req = 0; tick = 0; step(); step();
  endtask

  task automatic wait_tv(input int v, input string nm);
    int b = 0;
    while (!(busy && time_val == 3'(v)) && b < 30) begin
      step(); b++; n_chk++;
      if (obs() !== expv()) begin n_fail++; $display("FAIL %s obs=%h exp=%h", nm, obs(), expv()); end
    end
    if (b >= 30) begin n_chk++; n_fail++; $display("FAIL %s_timeout tv=%0d exp=%0d", nm, time_val, v); end
  endtask

  task automatic test_abort();
    req = 4'b0010; tick = 1;
    wait_tv(3, "abort");
    req = 4'b0000; step(); n_chk++;
    if (obs() !== expv() || gnt !== 0 || time_val !== 0 || busy !== 0 || timeout !== 0) begin
      n_fail++; $display("FAIL abort_drop obs=%h exp=%h", obs(), expv());
    end
    req = 4'b0110; step(); n_chk++;
    if (gnt !== 4'b0100 || obs() !== expv()) begin n_fail++; $display("FAIL abort_next gnt=%b exp=0100", gnt); end
    req = 0; step(); step();
  endtask

  task automatic test_collision();
    req = 4'b0001; tick = 1;
    wait_tv(TMO, "collision");
    req = 0;
    for (int i = 0; i < 3; i++) begin
      step(); n_chk++;
      if (timeout !== 0 || busy !== 0 || obs() !== expv()) begin
        n_fail++; $display("FAIL collision to=%b busy=%b exp to=0000 busy=0", timeout, busy);
      end
    end
  endtask

  task automatic test_async_reset();
    req = 4'b0010; tick = 1;
    wait_tv(4, "async_reset");
    #2 rst = 1;
    #1 n_chk++;
    if (obs() !== 14'd0) begin n_fail++; $display("FAIL async_reset_clear obs=%h exp=0", obs()); end
    mreset();
    req = 4'b1001;
    step(); rst = 0;
    step(); n_chk++;
    if (gnt !== 4'b0001 || obs() !== expv()) begin n_fail++; $display("FAIL async_reset_regrant gnt=%b exp=0001", gnt); end
    req = 0; step(); step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7) == 0) req = 4'($urandom);
      tick = 1'($urandom);
      step(); n_chk++;
      if (obs() !== expv()) begin n_fail++; $display("FAIL random cyc=%0d obs=%h exp=%h", i, obs(), expv()); end
    end
  endtask

  initial begin
    mreset();
    test_reset();
    test_single();
    test_fairness();
    test_tick_gating();
    test_abort();
    test_collision();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
